request_dispatcher: RTL and testbench

Dequeue-side partner of the frontend request FIFO. Pops `frontend_command_t` entries from the FIFO's show-ahead head, holds each in a one-entry output stage, and issues it over a valid/ready handshake to the bank controller addressed by its bank field; REFRESH is broadcast to all banks. It sits between the request FIFO and the per-bank controllers, preserves strict FIFO order, and sustains one command per cycle when the target is ready.

---
 rtl/frontend_command_definition_pkg.sv | 30 +++
 rtl/open_row_table.sv | 49 ++++
 rtl/request_dispatcher.sv | 116 +++++++++++
 tb/tb_request_dispatcher.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command format, op encodings and dispatcher FSM states.
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 2
`endif

package frontend_command_definition_pkg;

  localparam int BANK_ADDR_BITS = `BANK_ADDR_BITS;
  localparam int BANK_COUNT     = 1 << BANK_ADDR_BITS;
  localparam int ROW_BITS       = 14;
  localparam int COL_BITS       = 10;

  localparam logic [1:0] OP_READ      = 2'b00;
  localparam logic [1:0] OP_WRITE     = 2'b01;
  localparam logic [1:0] OP_PRECHARGE = 2'b10;
  localparam logic [1:0] OP_REFRESH   = 2'b11;

  typedef struct packed {
    logic [1:0]                op;
    logic [BANK_ADDR_BITS-1:0] bank;
    logic [ROW_BITS-1:0]       row;
    logic [COL_BITS-1:0]       col;
  } frontend_command_t;

  typedef enum logic {
    ST_IDLE,
    ST_HOLD
  } dispatch_state_t;

endpackage

// File: rtl/open_row_table.sv
// Per-bank open-row tracker; lookup sees the table as it will be after this cycle's transfer.
// Latency: lkp_hit is combinational. Backpressure: none, updates only on upd_en.
module open_row_table
  import frontend_command_definition_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      upd_en,
  input  logic [1:0]                upd_op,
  input  logic [BANK_ADDR_BITS-1:0] upd_bank,
  input  logic [ROW_BITS-1:0]       upd_row,
  input  logic [BANK_ADDR_BITS-1:0] lkp_bank,
  input  logic [ROW_BITS-1:0]       lkp_row,
  output logic                      lkp_hit
);

  logic [BANK_COUNT-1:0] vld_q;
  logic [BANK_COUNT-1:0] vld_d;
  logic [ROW_BITS-1:0]   row_q [BANK_COUNT];
  logic [ROW_BITS-1:0]   row_d [BANK_COUNT];

  always_comb begin
    vld_d = vld_q;
    row_d = row_q;
    if (upd_en) begin
      case (upd_op)
        OP_READ, OP_WRITE: begin
          vld_d[upd_bank] = 1'b1;
          row_d[upd_bank] = upd_row;
        end
        OP_PRECHARGE: vld_d[upd_bank] = 1'b0;
        default:      vld_d = '0;
      endcase
    end
  end

  // Compare against next state so a transfer in the latch cycle is seen.
  assign lkp_hit = vld_d[lkp_bank] && (row_d[lkp_bank] == lkp_row);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/request_dispatcher.sv
// Pops the request FIFO head into a one-entry stage and issues it to its bank (REFRESH to all); DISPATCH_ROW_HIT_EN adds row-hit tracking.
// Latency: pop in cycle N, bank valid in N+1; one command per cycle when the target is ready.
// Backpressure: a stalled head blocks the FIFO until every addressed bank takes it.
module request_dispatcher
  import frontend_command_definition_pkg::*;
#(
  parameter int BANK_NUM  = BANK_COUNT,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  frontend_command_t    i_fifo_data,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  output logic [BANK_NUM-1:0]  o_bank_valid,
  input  logic [BANK_NUM-1:0]  i_bank_ready,
  output frontend_command_t    o_bank_cmd,
  output logic                 o_row_hit,
  output logic [CNT_WIDTH-1:0] o_issue_cnt,
  output logic                 o_busy
);

  dispatch_state_t      state_q;
  dispatch_state_t      state_d;
  frontend_command_t    cmd_q;
  logic [BANK_NUM-1:0]  vld_q;
  logic [BANK_NUM-1:0]  pop_mask;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 xfer;
  logic                 can_pop;

  assign can_pop = !i_fifo_empty && !i_rst;

  always_comb begin
    pop_mask = '0;
    if (i_fifo_data.op == OP_REFRESH) pop_mask = '1;
    else                              pop_mask[i_fifo_data.bank] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    xfer         = 1'b0;
    o_fifo_rd_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          o_fifo_rd_en = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // REFRESH drives all valids, so it completes only when every bank is ready.
        if (cmd_q.op == OP_REFRESH) xfer = &i_bank_ready;
        else                        xfer = |(vld_q & i_bank_ready);
        if (xfer) begin
          if (can_pop) o_fifo_rd_en = 1'b1;
          else         state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_q <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      if (o_fifo_rd_en) begin
        cmd_q <= i_fifo_data;
        vld_q <= pop_mask;
      end else if (xfer) begin
        vld_q <= '0;
      end
      if (xfer) cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

`ifdef DISPATCH_ROW_HIT_EN
  logic hit_d;
  logic hit_q;

  open_row_table u_open_row_table (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .upd_en   (xfer),
    .upd_op   (cmd_q.op),
    .upd_bank (cmd_q.bank),
    .upd_row  (cmd_q.row),
    .lkp_bank (i_fifo_data.bank),
    .lkp_row  (i_fifo_data.row),
    .lkp_hit  (hit_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst)             hit_q <= 1'b0;
    else if (o_fifo_rd_en) hit_q <= hit_d;
  end

  assign o_row_hit = hit_q;
`else
  assign o_row_hit = 1'b0;
`endif

  assign o_bank_valid = vld_q;
  assign o_bank_cmd   = cmd_q;
  assign o_issue_cnt  = cnt_q;
  assign o_busy       = (state_q == ST_HOLD);

endmodule

// File: tb/tb_request_dispatcher.sv
// Randomized and directed bench for request_dispatcher against a transaction-level model.
module tb_request_dispatcher;
  import frontend_command_definition_pkg::*;

  localparam int CW = 4;
`ifdef DISPATCH_ROW_HIT_EN
  localparam bit ROW_EN = 1'b1;
`else
  localparam bit ROW_EN = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  frontend_command_t     i_fifo_data;
  logic                  i_fifo_empty;
  logic                  o_fifo_rd_en;
  logic [BANK_COUNT-1:0] o_bank_valid;
  logic [BANK_COUNT-1:0] i_bank_ready;
  frontend_command_t     o_bank_cmd;
  logic                  o_row_hit;
  logic [CW-1:0]         o_issue_cnt;
  logic                  o_busy;

  always #5 i_clk = ~i_clk;

  request_dispatcher #(.BANK_NUM(BANK_COUNT), .CNT_WIDTH(CW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_fifo_data  (i_fifo_data),
    .i_fifo_empty (i_fifo_empty),
    .o_fifo_rd_en (o_fifo_rd_en),
    .o_bank_valid (o_bank_valid),
    .i_bank_ready (i_bank_ready),
    .o_bank_cmd   (o_bank_cmd),
    .o_row_hit    (o_row_hit),
    .o_issue_cnt  (o_issue_cnt),
    .o_busy       (o_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // FIFO contents and the model's view of the output stage and open rows.
  frontend_command_t   fq[$];
  bit                  m_busy;
  frontend_command_t   m_cmd;
  bit                  m_hit;
  int                  m_cnt;
  bit                  ov   [BANK_COUNT];
  logic [ROW_BITS-1:0] orow [BANK_COUNT];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic frontend_command_t mk(input logic [1:0] op, input int bank, input int row);
    frontend_command_t c;
    c      = '0;
    c.op   = op;
    c.bank = BANK_ADDR_BITS'(bank);
    c.row  = ROW_BITS'(row);
    c.col  = COL_BITS'($urandom);
    return c;
  endfunction

  function automatic frontend_command_t rnd_cmd();
    logic [1:0] op;
    int r;
    r  = $urandom_range(0, 9);
    op = (r < 4) ? OP_READ : (r < 7) ? OP_WRITE : (r < 9) ? OP_PRECHARGE : OP_REFRESH;
    return mk(op, $urandom_range(0, BANK_COUNT - 1), $urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_hit  = 1'b0;
    m_cnt  = 0;
    m_cmd  = '0;
    for (int b = 0; b < BANK_COUNT; b++) ov[b] = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic step(input logic [BANK_COUNT-1:0] rdy, input bit vis);
    logic [BANK_COUNT-1:0] exp_vld;
    frontend_command_t head;
    bit xfer;
    bit pop;
    i_bank_ready = rdy;
    i_fifo_empty = !(vis && fq.size() > 0);
    head         = (fq.size() > 0) ? fq[0] : '0;
    i_fifo_data  = head;
    #1;
    exp_vld = '0;
    xfer    = 1'b0;
    if (m_busy) begin
      if (m_cmd.op == OP_REFRESH) begin
        exp_vld = '1;
        xfer    = (rdy == '1);
      end else begin
        exp_vld[m_cmd.bank] = 1'b1;
        xfer                = rdy[m_cmd.bank];
      end
    end
    pop = !i_fifo_empty && (!m_busy || xfer);

    chk("busy",   64'(o_busy),       64'(m_busy));
    chk("valid",  64'(o_bank_valid), 64'(exp_vld));
    chk("cnt",    64'(o_issue_cnt),  64'(m_cnt));
    chk("rd_en",  64'(o_fifo_rd_en), 64'(pop));
    if (m_busy) begin
      chk("cmd",     64'(o_bank_cmd), 64'(m_cmd));
      chk("row_hit", 64'(o_row_hit),  64'(m_hit));
    end

    if (xfer) begin
      m_cnt = (m_cnt + 1) % (1 << CW);
      case (m_cmd.op)
        OP_READ, OP_WRITE: begin
          ov[m_cmd.bank]   = 1'b1;
          orow[m_cmd.bank] = m_cmd.row;
        end
        OP_PRECHARGE: ov[m_cmd.bank] = 1'b0;
        default: for (int b = 0; b < BANK_COUNT; b++) ov[b] = 1'b0;
      endcase
    end
    if (pop) begin
      m_hit  = ROW_EN && ov[head.bank] && (orow[head.bank] == head.row);
      m_cmd  = head;
      m_busy = 1'b1;
      void'(fq.pop_front());
    end else if (xfer) begin
      m_busy = 1'b0;
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    i_rst        = 1'b1;
    i_bank_ready = '0;
    repeat (cycles) begin
      i_fifo_empty = (fq.size() == 0);
      i_fifo_data  = (fq.size() > 0) ? fq[0] : '0;
      #1;
      chk("rst_rd_en", 64'(o_fifo_rd_en), 64'(0));
      @(posedge i_clk);
      #1;
    end
    i_rst = 1'b0;
    model_reset();
    chk("rst_valid", 64'(o_bank_valid), 64'(0));
    chk("rst_cmd",   64'(o_bank_cmd),   64'(0));
    chk("rst_hit",   64'(o_row_hit),    64'(0));
    chk("rst_cnt",   64'(o_issue_cnt),  64'(0));
    chk("rst_busy",  64'(o_busy),       64'(0));
  endtask

  initial begin
    i_rst        = 1'b1;
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    i_bank_ready = '0;
    model_reset();
    @(posedge i_clk);
    #1;
    do_reset(3);

    // Idle with an empty FIFO.
    repeat (10) step('0, 1'b1);

    // Back-to-back reads to one bank: rows 5, 5, 7.
    fq.push_back(mk(OP_READ, 2, 5));
    fq.push_back(mk(OP_READ, 2, 5));
    fq.push_back(mk(OP_READ, 2, 7));
    repeat (5) step(BANK_COUNT'(4'b0100), 1'b1);

    // Head-of-line block: WRITE to bank 1 stalled, READ to bank 0 waits.
    fq.push_back(mk(OP_WRITE, 1, 9));
    fq.push_back(mk(OP_READ, 0, 3));
    step(BANK_COUNT'(4'b1101), 1'b1);
    repeat (4) step(BANK_COUNT'(4'b1101), 1'b1);
    repeat (3) step('1, 1'b1);

    // REFRESH needs every bank ready; it closes all rows.
    fq.push_back(mk(OP_READ, 2, 5));
    fq.push_back(mk(OP_REFRESH, 0, 0));
    fq.push_back(mk(OP_READ, 2, 5));
    step('1, 1'b1);
    repeat (4) step(BANK_COUNT'(4'b1011), 1'b1);
    repeat (3) step('1, 1'b1);

    // Reset while holding a command: it must be dropped.
    fq.push_back(mk(OP_WRITE, 3, 1));
    repeat (3) step('0, 1'b1);
    do_reset(1);
    repeat (3) step('1, 1'b1);

    // Counter wrap: 17 transfers on a 4-bit counter.
    for (int i = 0; i < 17; i++) fq.push_back(mk(OP_READ, i % BANK_COUNT, i % 3));
    repeat (20) step('1, 1'b1);
    chk("cnt_wrap", 64'(o_issue_cnt), 64'(1));

    // Randomized traffic, ready patterns and FIFO gaps.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1 && fq.size() < 8) fq.push_back(rnd_cmd());
      step(($urandom_range(0, 1) == 1) ? '1 : BANK_COUNT'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (40) step('1, 1'b1);
    chk("drained", 64'(fq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
